// File: rtl/cabin_sign_sequencer.sv
// Cabin sign/lighting sequencer: applies command pulses, drives chime, lockout.
// Ports: clk, reset (sync, active-high), seatbelt_pulse, lighting_pulse,
//   emergency -> allow_cmds, seatbelt_sign, light_mode[1:0], chime, busy.
// Optional macro LIGHT_CHIME_EN: lighting commands also sound the chime.
module cabin_sign_sequencer #(
    parameter int CHIME_CYCLES   = 8,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       seatbelt_pulse,
    input  logic       lighting_pulse,
    input  logic       emergency,
    output logic       allow_cmds,
    output logic       seatbelt_sign,
    output logic [1:0] light_mode,
    output logic       chime,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHIME   = 2'd1,
        LOCKOUT = 2'd2,
        EMERG   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CHIME_LOAD = CNT_W'(CHIME_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCKOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic [1:0]       light_q, light_d;
    logic             chime_q, chime_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            light_q <= 2'b00;
            chime_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            light_q <= light_d;
            chime_q <= chime_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        light_d = light_q;
        chime_d = chime_q;
        if (emergency) begin
            // Override wins over every transition and any same-cycle pulse.
            state_d = EMERG;
            cnt_d   = '0;
            sign_d  = 1'b1;
            light_d = 2'b10;
            chime_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (seatbelt_pulse) begin
                        sign_d  = ~sign_q;
                        if (lighting_pulse)
                            light_d = light_q + 2'd1;
                        state_d = CHIME;
                        cnt_d   = CHIME_LOAD;
                        chime_d = 1'b1;
                    end else if (lighting_pulse) begin
                        light_d = light_q + 2'd1;
`ifdef LIGHT_CHIME_EN
                        state_d = CHIME;
                        cnt_d   = CHIME_LOAD;
                        chime_d = 1'b1;
`else
                        state_d = LOCKOUT;
                        cnt_d   = LOCK_LOAD;
`endif
                    end
                end
                CHIME: begin
                    chime_d = 1'b1;
                    if (cnt_q == '0) begin
                        chime_d = 1'b0;
                        state_d = LOCKOUT;
                        cnt_d   = LOCK_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (cnt_q == '0)
                        state_d = IDLE;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
                EMERG: begin
                    // Emergency has dropped: hold sign/light, cool down.
                    state_d = LOCKOUT;
                    cnt_d   = LOCK_LOAD;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    assign allow_cmds    = (state_q == IDLE) && !emergency && !reset;
    assign seatbelt_sign = sign_q;
    assign light_mode    = light_q;
    assign chime         = chime_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_cabin_sign_sequencer.sv
// Scoreboard bench for cabin_sign_sequencer: directed plus random commands,
// expected outputs from a deadline-based model of the command timing rules.
module tb_cabin_sign_sequencer;

    localparam int CH   = 8;
    localparam int LOCK = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       seatbelt_pulse = 1'b0;
    logic       lighting_pulse = 1'b0;
    logic       emergency = 1'b0;
    logic       allow_cmds;
    logic       seatbelt_sign;
    logic [1:0] light_mode;
    logic       chime;
    logic       busy;

    cabin_sign_sequencer #(
        .CHIME_CYCLES(CH),
        .LOCKOUT_CYCLES(LOCK),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .seatbelt_pulse(seatbelt_pulse),
        .lighting_pulse(lighting_pulse),
        .emergency(emergency),
        .allow_cmds(allow_cmds),
        .seatbelt_sign(seatbelt_sign),
        .light_mode(light_mode),
        .chime(chime),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_no;
        logic       sign;
        logic [1:0] light;
        logic       chime;
        logic       busy;
        logic       allow;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int passed = 0;

    // Model: cycle numbers of the last chime-high edge and of the edge
    // after which the block is idle again.
    logic       m_sign;
    logic [1:0] m_light;
    int         m_chime_last;
    int         m_idle_edge;
    bit         m_emerg;
    int         k = 0;

    task automatic model(input bit rst, input bit sb, input bit lt,
                         input bit em);
        exp_t e;
        if (rst) begin
            m_sign = 1'b0;
            m_light = 2'b00;
            m_chime_last = -1;
            m_idle_edge = k;
            m_emerg = 1'b0;
        end else if (em) begin
            m_emerg = 1'b1;
            m_sign = 1'b1;
            m_light = 2'b10;
            m_chime_last = -1;
            m_idle_edge = 32'h3fff_ffff;
        end else if (m_emerg) begin
            m_emerg = 1'b0;
            m_idle_edge = k + LOCK;
        end else if (m_idle_edge < k) begin
            if (sb) begin
                m_sign = ~m_sign;
                if (lt) m_light = m_light + 2'd1;
                m_chime_last = k + CH - 1;
                m_idle_edge = k + CH + LOCK;
            end else if (lt) begin
                m_light = m_light + 2'd1;
`ifdef LIGHT_CHIME_EN
                m_chime_last = k + CH - 1;
                m_idle_edge = k + CH + LOCK;
`else
                m_idle_edge = k + LOCK;
`endif
            end
        end
        e.edge_no = k;
        e.sign = m_sign;
        e.light = m_light;
        e.chime = (k <= m_chime_last);
        e.busy = (m_idle_edge > k);
        e.allow = !e.busy && !em && !rst;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rst, input bit sb, input bit lt,
                        input bit em);
        @(negedge clk);
        reset = rst;
        seatbelt_pulse = sb;
        lighting_pulse = lt;
        emergency = em;
        @(posedge clk);
        #1;
        k++;
        model(rst, sb, lt, em);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input int e_no,
                       input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act === req)
            passed++;
        else
            $display("FAIL %s edge %0d: got %0h expected %0h",
                     name, e_no, act, req);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("seatbelt_sign", e.edge_no, {1'b0, seatbelt_sign},
                    {1'b0, e.sign});
                chk("light_mode", e.edge_no, light_mode, e.light);
                chk("chime", e.edge_no, {1'b0, chime}, {1'b0, e.chime});
                chk("busy", e.edge_no, {1'b0, busy}, {1'b0, e.busy});
                chk("allow_cmds", e.edge_no, {1'b0, allow_cmds},
                    {1'b0, e.allow});
            end
        end
    end

    initial begin : driver
        int guard;
        // Reset for three cycles, then release.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        idle_n(2);
        // Seatbelt on, full chime + lockout, then off again.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle_n(CH + LOCK + 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle_n(CH + LOCK + 1);
        // Four lighting commands walk the mode around.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            idle_n(LOCK + 1);
        end
        // Both pulses together, then a pulse during lockout is ignored.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        idle_n(CH + 3);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        idle_n(LOCK);
        // Emergency mid-chime, held, then released into lockout.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle_n(3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        idle_n(LOCK + 2);
        // Reset in lockout with five counts left.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle_n(LOCK - 6);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle_n(2);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit em;
            r = int'($urandom_range(0, 99));
            em = (r < 4) || (emergency && r < 60);
            step(r == 99, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0, em);
        end
        idle_n(2);
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0",
                     exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
